// File: rtl/simon_says_core.sv
// Simon-says game core: LFSR-driven sequence generation, timed LED playback and player echo checking.
// Optional input timeout in ACCEPT is built when the SIMON_TIMEOUT_EN macro is defined.
module simon_says_core #(
  parameter int          NUM_CH         = 4,
  parameter int          MAX_LEN        = 10,
  parameter int          BLINK_CYCLES   = 25000000,
  parameter int          GAP_CYCLES     = 12500000,
  parameter int          TIMEOUT_CYCLES = 250000000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                         CLOCK_50,
  input  logic                         KEY0,
  input  logic                         start,
  input  logic [NUM_CH-1:0]            sw,
  output logic [NUM_CH-1:0]            led,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic [2:0]                   state,
  output logic                         win,
  output logic                         lose
);

  localparam int IW   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int XW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CMAX = (BLINK_CYCLES > GAP_CYCLES) ? BLINK_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GEN       = 3'd1,
    S_BLINK_ON  = 3'd2,
    S_BLINK_OFF = 3'd3,
    S_ACCEPT    = 3'd4,
    S_CHECK     = 3'd5,
    S_WIN       = 3'd6,
    S_LOSE      = 3'd7
  } state_t;

  state_t            state_r, state_s;
  logic [LW-1:0]     level_r, level_s;
  logic [XW-1:0]     index_r, index_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [15:0]       lfsr_r;
  logic [NUM_CH-1:0] sw_prev_r, cap_r, cap_s, blink_led_r, blink_led_s;
  logic              win_r, win_s, lose_r, lose_s;
  logic              mem_we_s, press_s, timeout_s;
  logic [IW-1:0]     raw_s, rand_sym_s, blink_sym_s;
  logic [IW-1:0]     mem_r [MAX_LEN];

  function automatic logic [NUM_CH-1:0] onehot(input logic [IW-1:0] v);
    return {{(NUM_CH-1){1'b0}}, 1'b1} << v;
  endfunction

  assign raw_s      = lfsr_r[IW-1:0];
  assign rand_sym_s = (raw_s >= IW'(NUM_CH)) ? raw_s - IW'(NUM_CH) : raw_s;
  assign press_s    = (sw_prev_r == '0) && (sw != '0);

`ifdef SIMON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_r;

  // Idle-cycle counter for ACCEPT; cleared outside ACCEPT and on every press.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0)                            tcnt_r <= '0;
    else if (state_r != S_ACCEPT || press_s) tcnt_r <= '0;
    else                                  tcnt_r <= tcnt_r + TW'(1);
  end

  assign timeout_s = (tcnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and datapath updates for the game FSM.
  always_comb begin
    state_s  = state_r;
    level_s  = level_r;
    index_s  = index_r;
    cnt_s    = cnt_r;
    cap_s    = cap_r;
    win_s    = win_r;
    lose_s   = lose_r;
    mem_we_s = 1'b0;
    case (state_r)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_s = S_GEN;
          level_s = '0;
          win_s   = 1'b0;
          lose_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_GEN: begin
        mem_we_s = 1'b1;
        level_s  = level_r + LW'(1);
        index_s  = '0;
        cnt_s    = '0;
        state_s  = S_BLINK_ON;
      end
      S_BLINK_ON: begin
        if (cnt_r == CW'(BLINK_CYCLES - 1)) begin
          cnt_s   = '0;
          state_s = S_BLINK_OFF;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_BLINK_OFF: begin
        if (cnt_r == CW'(GAP_CYCLES - 1)) begin
          cnt_s = '0;
          if (LW'(index_r) + LW'(1) < level_r) begin
            index_s = index_r + XW'(1);
            state_s = S_BLINK_ON;
          end else begin
            index_s = '0;
            state_s = S_ACCEPT;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_ACCEPT: begin
        if (press_s) begin
          cap_s   = sw;
          state_s = S_CHECK;
        end else if (timeout_s) begin
          lose_s  = 1'b1;
          state_s = S_LOSE;
        end else begin
          state_s = S_ACCEPT;
        end
      end
      S_CHECK: begin
        if (cap_r == onehot(mem_r[index_r])) begin
          if (LW'(index_r) + LW'(1) < level_r) begin
            index_s = index_r + XW'(1);
            state_s = S_ACCEPT;
          end else if (level_r < LW'(MAX_LEN)) begin
            state_s = S_GEN;
          end else begin
            win_s   = 1'b1;
            state_s = S_WIN;
          end
        end else begin
          lose_s  = 1'b1;
          state_s = S_LOSE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Playback LED is registered one cycle ahead; at level 0 the symbol being written is bypassed.
  always_comb begin
    if (state_r == S_GEN && level_r == '0) blink_sym_s = rand_sym_s;
    else                                   blink_sym_s = mem_r[index_s];
    if (state_s == S_BLINK_ON) blink_led_s = onehot(blink_sym_s);
    else                       blink_led_s = '0;
  end

  // State, counters, flags and LFSR registers.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_r     <= S_IDLE;
      level_r     <= '0;
      index_r     <= '0;
      cnt_r       <= '0;
      lfsr_r      <= LFSR_SEED;
      sw_prev_r   <= '0;
      cap_r       <= '0;
      win_r       <= 1'b0;
      lose_r      <= 1'b0;
      blink_led_r <= '0;
    end else begin
      state_r     <= state_s;
      level_r     <= level_s;
      index_r     <= index_s;
      cnt_r       <= cnt_s;
      lfsr_r      <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      sw_prev_r   <= sw;
      cap_r       <= cap_s;
      win_r       <= win_s;
      lose_r      <= lose_s;
      blink_led_r <= blink_led_s;
    end
  end

  // Sequence memory has no reset; only entries below level are ever read.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we_s) mem_r[XW'(level_r)] <= rand_sym_s;
  end

  assign led   = (state_r == S_ACCEPT) ? sw : blink_led_r;
  assign level = level_r;
  assign state = state_r;
  assign win   = win_r;
  assign lose  = lose_r;

endmodule

// File: tb/tb_simon_says_core.sv
// Self-checking bench for simon_says_core: 4-channel and 3-channel instances, MAX_LEN=3, BLINK=2, GAP=1.
// Expected symbols come from a bench-side LFSR model stepped once per clock edge.
module tb_simon_says_core;
  localparam int          MAXL = 3;
  localparam int          BLK  = 2;
  localparam int          GAP  = 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       key0, start4, start3;
  logic [3:0] sw4, led4;
  logic [2:0] sw3, led3;
  logic [1:0] level4, level3;
  logic [2:0] state4, state3;
  logic       win4, lose4, win3, lose3;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr;
  int          seq4[$];
  int          seq3[$];

  always #5 clk = ~clk;

  simon_says_core #(.NUM_CH(4), .MAX_LEN(MAXL), .BLINK_CYCLES(BLK), .GAP_CYCLES(GAP),
                    .TIMEOUT_CYCLES(8), .LFSR_SEED(SEED)) dut (
    .CLOCK_50(clk), .KEY0(key0), .start(start4), .sw(sw4), .led(led4),
    .level(level4), .state(state4), .win(win4), .lose(lose4));

  simon_says_core #(.NUM_CH(3), .MAX_LEN(MAXL), .BLINK_CYCLES(BLK), .GAP_CYCLES(GAP),
                    .TIMEOUT_CYCLES(8), .LFSR_SEED(SEED)) dut3 (
    .CLOCK_50(clk), .KEY0(key0), .start(start3), .sw(sw3), .led(led3),
    .level(level3), .state(state3), .win(win3), .lose(lose3));

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int model_sym(input logic [15:0] l, input int nch);
    int iw, v;
    iw = (nch > 2) ? $clog2(nch) : 1;
    v  = int'(l) & ((1 << iw) - 1);
    if (v >= nch) v = v - nch;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    if (key0) m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  task automatic start_game4;
    int d;
    d = int'($urandom_range(0, 5));
    repeat (d) tick;
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    checks++;
    if (state4 !== 3'd1 || win4 !== 1'b0 || lose4 !== 1'b0 || level4 !== 2'd0) begin
      errors++;
      $display("FAIL start_to_gen: got state=%0d win=%b lose=%b level=%0d, expected state=1 win=0 lose=0 level=0",
               state4, win4, lose4, level4);
    end
    seq4.delete();
  endtask

  task automatic playback4;
    checks++;
    if (state4 !== 3'd1) begin
      errors++;
      $display("FAIL gen_state: got state=%0d, expected 1", state4);
    end
    seq4.push_back(model_sym(m_lfsr, 4));
    tick;
    for (int i = 0; i < seq4.size(); i++) begin
      for (int c = 0; c < BLK; c++) begin
        checks++;
        if (state4 !== 3'd2 || led4 !== 4'(1 << seq4[i]) || level4 !== 2'(seq4.size())) begin
          errors++;
          $display("FAIL blink_on[%0d]: got state=%0d led=%b level=%0d, expected state=2 led=%b level=%0d",
                   i, state4, led4, level4, 4'(1 << seq4[i]), seq4.size());
        end
        tick;
      end
      for (int c = 0; c < GAP; c++) begin
        checks++;
        if (state4 !== 3'd3 || led4 !== 4'd0) begin
          errors++;
          $display("FAIL blink_off[%0d]: got state=%0d led=%b, expected state=3 led=0000", i, state4, led4);
        end
        tick;
      end
    end
    checks++;
    if (state4 !== 3'd4) begin
      errors++;
      $display("FAIL accept_entry: got state=%0d, expected 4", state4);
    end
  endtask

  task automatic entries4(input int wrong_idx, input logic [3:0] wrong_val);
    int d, exp_st;
    logic [3:0] v;
    for (int i = 0; i < seq4.size(); i++) begin
      d = int'($urandom_range(0, 3));
      repeat (d) begin
        checks++;
        if (state4 !== 3'd4 || led4 !== 4'd0) begin
          errors++;
          $display("FAIL accept_wait: got state=%0d led=%b, expected state=4 led=0000", state4, led4);
        end
        tick;
      end
      v = (i == wrong_idx) ? wrong_val : 4'(1 << seq4[i]);
      sw4 = v;
      #1;
      checks++;
      if (led4 !== v || state4 !== 3'd4) begin
        errors++;
        $display("FAIL echo: got state=%0d led=%b, expected state=4 led=%b", state4, led4, v);
      end
      tick;
      sw4 = 4'd0;
      checks++;
      if (state4 !== 3'd5 || led4 !== 4'd0) begin
        errors++;
        $display("FAIL check_state: got state=%0d led=%b, expected state=5 led=0000", state4, led4);
      end
      tick;
      if (i == wrong_idx) begin
        checks++;
        if (state4 !== 3'd7 || lose4 !== 1'b1 || win4 !== 1'b0 || level4 !== 2'(seq4.size())) begin
          errors++;
          $display("FAIL lose_result: got state=%0d lose=%b win=%b level=%0d, expected state=7 lose=1 win=0 level=%0d",
                   state4, lose4, win4, level4, seq4.size());
        end
        return;
      end
      exp_st = (i < seq4.size() - 1) ? 4 : ((seq4.size() < MAXL) ? 1 : 6);
      checks++;
      if (state4 !== 3'(exp_st)) begin
        errors++;
        $display("FAIL after_check[%0d]: got state=%0d, expected %0d", i, state4, exp_st);
      end
    end
  endtask

  task automatic test_reset;
    key0 = 1'b0; start4 = 1'b0; start3 = 1'b0; sw4 = 4'd0; sw3 = 3'd0;
    m_lfsr = SEED;
    #3;
    checks++;
    if (state4 !== 3'd0 || led4 !== 4'd0 || level4 !== 2'd0 || win4 !== 1'b0 || lose4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4: got state=%0d led=%b level=%0d win=%b lose=%b, expected all zero",
               state4, led4, level4, win4, lose4);
    end
    checks++;
    if (state3 !== 3'd0 || led3 !== 3'd0 || level3 !== 2'd0 || win3 !== 1'b0 || lose3 !== 1'b0) begin
      errors++;
      $display("FAIL reset3: got state=%0d led=%b level=%0d win=%b lose=%b, expected all zero",
               state3, led3, level3, win3, lose3);
    end
    tick;
    key0 = 1'b1;
  endtask

  task automatic test_full_game;
    start_game4;
    for (int lvl = 1; lvl <= MAXL; lvl++) begin
      playback4;
      entries4(-1, 4'd0);
    end
    repeat (3) begin
      checks++;
      if (state4 !== 3'd6 || win4 !== 1'b1 || lose4 !== 1'b0 || level4 !== 2'd3 || led4 !== 4'd0) begin
        errors++;
        $display("FAIL win_hold: got state=%0d win=%b lose=%b level=%0d led=%b, expected state=6 win=1 lose=0 level=3 led=0000",
                 state4, win4, lose4, level4, led4);
      end
      tick;
    end
  endtask

  task automatic test_lose;
    int w;
    start_game4;
    playback4;
    entries4(-1, 4'd0);
    playback4;
    w = (seq4[1] + 1 + int'($urandom_range(0, 2))) % 4;
    entries4(1, 4'(1 << w));
    start_game4;
    playback4;
  endtask

  task automatic test_multibit;
    entries4(0, 4'b0011);
  endtask

  task automatic test_hold_press;
    int nchk;
    start_game4;
    playback4;
    entries4(-1, 4'd0);
    playback4;
    sw4 = 4'(1 << seq4[0]);
    #1;
    tick;
    nchk = (state4 === 3'd5) ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (state4 === 3'd5) nchk++;
    end
    checks++;
    if (nchk !== 1 || state4 !== 3'd4) begin
      errors++;
      $display("FAIL hold_single_check: got checks_seen=%0d state=%0d, expected checks_seen=1 state=4", nchk, state4);
    end
    sw4 = 4'd0;
    tick;
    sw4 = 4'(1 << seq4[1]);
    tick;
    sw4 = 4'd0;
    checks++;
    if (state4 !== 3'd5) begin
      errors++;
      $display("FAIL hold_second_press: got state=%0d, expected 5", state4);
    end
    tick;
    checks++;
    if (state4 !== 3'd1) begin
      errors++;
      $display("FAIL hold_level_done: got state=%0d, expected 1", state4);
    end
  endtask

  task automatic test_timeout;
    playback4;
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    checks++;
    if (state4 !== 3'd4) begin
      errors++;
      $display("FAIL start_ignored: got state=%0d, expected 4", state4);
    end
`ifdef SIMON_TIMEOUT_EN
    for (int k = 3; k <= 8; k++) begin
      tick;
      checks++;
      if (state4 !== 3'd4) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got state=%0d, expected 4", k, state4);
      end
    end
    tick;
    checks++;
    if (state4 !== 3'd7 || lose4 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_lose: got state=%0d lose=%b, expected state=7 lose=1", state4, lose4);
    end
`else
    repeat (100) tick;
    checks++;
    if (state4 !== 3'd4 || lose4 !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: got state=%0d lose=%b, expected state=4 lose=0", state4, lose4);
    end
`endif
  endtask

  task automatic test_reset_midway;
    key0 = 1'b0;
    m_lfsr = SEED;
    tick;
    key0 = 1'b1;
    start_game4;
    tick;
    checks++;
    if (state4 !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_blink: got state=%0d, expected 2", state4);
    end
    #2;
    key0 = 1'b0;
    m_lfsr = SEED;
    #1;
    checks++;
    if (state4 !== 3'd0 || led4 !== 4'd0 || level4 !== 2'd0 || win4 !== 1'b0 || lose4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_blink: got state=%0d led=%b level=%0d win=%b lose=%b, expected all zero",
               state4, led4, level4, win4, lose4);
    end
    tick;
    key0 = 1'b1;
    start_game4;
    playback4;
    sw4 = 4'(1 << seq4[0]);
    tick;
    sw4 = 4'd0;
    #2;
    key0 = 1'b0;
    m_lfsr = SEED;
    #1;
    checks++;
    if (state4 !== 3'd0 || level4 !== 2'd0 || led4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_check: got state=%0d level=%0d led=%b, expected all zero", state4, level4, led4);
    end
    tick;
    key0 = 1'b1;
  endtask

  task automatic test_three_channels;
    logic [2:0] cap[$];
    int d;
    d = int'($urandom_range(0, 5));
    repeat (d) tick;
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    seq3.delete();
    for (int lvl = 1; lvl <= MAXL; lvl++) begin
      checks++;
      if (state3 !== 3'd1) begin
        errors++;
        $display("FAIL ch3_gen[%0d]: got state=%0d, expected 1", lvl, state3);
      end
      seq3.push_back(model_sym(m_lfsr, 3));
      tick;
      cap.delete();
      for (int i = 0; i < seq3.size(); i++) begin
        for (int c = 0; c < BLK; c++) begin
          checks++;
          if (!(led3 === 3'b001 || led3 === 3'b010 || led3 === 3'b100) || state3 !== 3'd2) begin
            errors++;
            $display("FAIL ch3_legal_led: got led=%b state=%0d, expected one of 001/010/100 in state 2", led3, state3);
          end
          checks++;
          if (led3 !== 3'(1 << seq3[i])) begin
            errors++;
            $display("FAIL ch3_model_led[%0d]: got led=%b, expected %b", i, led3, 3'(1 << seq3[i]));
          end
          if (c == 0) cap.push_back(led3);
          tick;
        end
        repeat (GAP) tick;
      end
      checks++;
      if (state3 !== 3'd4) begin
        errors++;
        $display("FAIL ch3_accept: got state=%0d, expected 4", state3);
      end
      for (int i = 0; i < cap.size(); i++) begin
        sw3 = cap[i];
        tick;
        sw3 = 3'd0;
        tick;
      end
    end
    checks++;
    if (state3 !== 3'd6 || win3 !== 1'b1 || level3 !== 2'd3 || lose3 !== 1'b0) begin
      errors++;
      $display("FAIL ch3_win: got state=%0d win=%b level=%0d lose=%b, expected state=6 win=1 level=3 lose=0",
               state3, win3, level3, lose3);
    end
  endtask

  initial begin
    test_reset;
    test_full_game;
    test_lose;
    test_multibit;
    test_hold_press;
    test_timeout;
    test_reset_midway;
    test_three_channels;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simon_says_core.md
SIMON_SAYS_CORE -- requirements
Module: simon_says_core

Interface
REQ-001 Parameter NUM_CH, default 4, number of button/LED channels, legal 2..8.
REQ-002 Parameter MAX_LEN, default 10, winning sequence length, legal 1..32.
REQ-003 Parameter BLINK_CYCLES, default 25000000, cycles each playback LED is lit, legal >=1.
REQ-004 Parameter GAP_CYCLES, default 12500000, dark cycles after each playback LED, legal >=1.
REQ-005 Parameter TIMEOUT_CYCLES, default 250000000, input timeout, used only under SIMON_TIMEOUT_EN.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, nonzero 16-bit random generator seed.
REQ-007 CLOCK_50  input  1  sole clock, rising edge.
REQ-008 KEY0  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  single-cycle request to begin a new game.
REQ-010 sw  input  NUM_CH  player switches, one bit per channel, synchronous to CLOCK_50.
REQ-011 led  output  NUM_CH  playback / echo LEDs.
REQ-012 level  output  clog2(MAX_LEN+1)  current sequence length.
REQ-013 state  output  3  FSM code: IDLE=0, GEN=1, BLINK_ON=2, BLINK_OFF=3, ACCEPT=4, CHECK=5, WIN=6, LOSE=7.
REQ-014 win, lose  output  1 each  game-result flags.

Function
REQ-015 Sequence memory: MAX_LEN entries of IW=max(1,clog2(NUM_CH)) bits; entries 0..level-1 valid.
REQ-016 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle in all states.
REQ-017 Random symbol = LFSR[IW-1:0], minus NUM_CH if >= NUM_CH, so it always lies in 0..NUM_CH-1.
REQ-018 IDLE/WIN/LOSE: start=1 -> GEN next cycle, level cleared to 0, win and lose cleared; start ignored in all other states.
REQ-019 GEN (1 cycle): writes the random symbol to entry level, increments level, resets playback index to 0 -> BLINK_ON.
REQ-020 BLINK_ON: led = one-hot(mem[index]) for exactly BLINK_CYCLES cycles -> BLINK_OFF.
REQ-021 BLINK_OFF: led = 0 for exactly GAP_CYCLES cycles; then index++ and -> BLINK_ON if index < level, else index=0 and -> ACCEPT.
REQ-022 Press = cycle where registered previous sw == 0 and current sw != 0; holding sw generates no further presses until all bits return to 0.
REQ-023 ACCEPT: led = sw; on a press, press value captured, -> CHECK next cycle.
REQ-024 CHECK (1 cycle): captured value must be exactly one-hot(mem[index]); multi-bit value is wrong.
REQ-025 CHECK correct, index < level-1: index++ -> ACCEPT.
REQ-026 CHECK correct, index == level-1, level < MAX_LEN: -> GEN.
REQ-027 CHECK correct, index == level-1, level == MAX_LEN: -> WIN; win=1 held.
REQ-028 CHECK wrong: -> LOSE; lose=1 held; level retains last value.
REQ-029 led = 0 in IDLE, GEN, CHECK, WIN, LOSE.

Reset
REQ-030 KEY0=0 forces, without a clock edge: state=IDLE, led=0, level=0, win=0, lose=0, index=0, counters=0, LFSR=LFSR_SEED.
REQ-031 Reset applies from any state including mid-playback and mid-CHECK; memory contents are don't-care after reset.

Configuration
REQ-032 Macro SIMON_TIMEOUT_EN defined: ACCEPT counts cycles since entry or last press; reaching TIMEOUT_CYCLES with no press -> LOSE.
REQ-033 Macro SIMON_TIMEOUT_EN undefined: no timeout counter exists; ACCEPT waits indefinitely.

Verification (NUM_CH=4, MAX_LEN=3, BLINK_CYCLES=2, GAP_CYCLES=1)
REQ-034 KEY0=0 asserted during BLINK_ON -> state=0, led=0, level=0, win=lose=0 before next clock edge.
REQ-035 start pulse in IDLE -> state=1 next cycle, level=1 after, led one-hot for exactly 2 cycles, 0 for 1 cycle, then state=4.
REQ-036 Bench replays captured playback (press 1 cycle, release 1 cycle) for levels 1,2,3 -> win=1, state=6, level=3; repeat with NUM_CH=3: every playback led is one of 3'b001/010/100.
REQ-037 Wrong key on second entry at level 2 -> state=7, lose=1, level=2; then start -> state=1, lose=0, level=1.
REQ-038 sw=4'b0011 press in ACCEPT -> state=5 then 7, lose=1; sw held nonzero 5 cycles after correct press -> only one CHECK.
REQ-039 SIMON_TIMEOUT_EN, TIMEOUT_CYCLES=8: no press 8 cycles in ACCEPT -> state=7; macro undefined: state=4 after 100 idle cycles.
